pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-fetch sequencer. It issues one memory request
// at a time and steers the program counter (increment, load on redirect,
// halt). Memory responses go to IF/ID directly, or through a one-entry
// buffer while the fetch stage is stalled.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | just out of reset; no request, moves to FETCH next cycle
// FETCH   | issue request at pc_i when not stalled, redirected or halting
// WAIT    | one request outstanding; waiting for imem_valid_i
// HOLD    | response parked in buffer until the stall clears
// HALTED  | no fetching; resume_i or a trap restarts
module pc_sequencer #(
  parameter int                   PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0]  TRAP_VEC    = PC_WIDTH'(32'h40),
  parameter int                   INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_WIDTH-1:0]    pc_i,
  output logic                   pc_load_o,
  output logic [PC_WIDTH-1:0]    pc_load_val_o,
  output logic                   pc_enable_o,
  input  logic                   stall_i,
  input  logic                   trap_i,
  input  logic                   br_redirect_i,
  input  logic [PC_WIDTH-1:0]    br_target_i,
  input  logic                   jmp_redirect_i,
  input  logic [PC_WIDTH-1:0]    jmp_target_i,
  input  logic                   halt_i,
  input  logic                   resume_i,
  output logic                   imem_req_o,
  input  logic                   imem_ready_i,
  input  logic                   imem_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   ifid_valid_o,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]    ifid_pc_o,
  output logic                   flush_ifid_o,
  output logic                   flush_idex_o,
  output logic                   halted_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t                 state_q;
  logic                   discard_q;
  logic [INSTR_WIDTH-1:0] buf_q;
  logic [PC_WIDTH-1:0]    req_pc_q;

  logic                   redirect;
  logic                   accept;
  logic [PC_WIDTH-1:0]    redir_val;
  logic                   deliver_wait;
  logic                   deliver_hold;

  // Redirect arbitration and all outputs; outputs are forced to zero during
  // reset because the state register only clears on the reset edge.
  always_comb begin
    redirect = trap_i | br_redirect_i | jmp_redirect_i;
    if (trap_i)             redir_val = TRAP_VEC;
    else if (br_redirect_i) redir_val = br_target_i;
    else                    redir_val = jmp_target_i;

    // While halted only a trap is honoured; IDLE ignores redirects.
    case (state_q)
      S_FETCH, S_WAIT, S_HOLD: accept = redirect;
      S_HALTED:                accept = trap_i;
      default:                 accept = 1'b0;
    endcase
    if (reset) accept = 1'b0;

    deliver_wait = !reset && (state_q == S_WAIT) && imem_valid_i &&
                   !discard_q && !accept && !stall_i;
    deliver_hold = !reset && (state_q == S_HOLD) && !stall_i && !accept;

    pc_load_o     = accept;
    pc_load_val_o = accept ? redir_val : '0;
    flush_ifid_o  = accept;
    flush_idex_o  = accept && (trap_i || br_redirect_i);
    imem_req_o    = !reset && (state_q == S_FETCH) && !stall_i && !redirect && !halt_i;
    pc_enable_o   = imem_req_o && imem_ready_i;
    halted_o      = !reset && (state_q == S_HALTED);

    ifid_valid_o = deliver_wait || deliver_hold;
    ifid_instr_o = '0;
    ifid_pc_o    = '0;
    if (deliver_wait) begin
      ifid_instr_o = imem_rdata_i;
      ifid_pc_o    = req_pc_q;
    end else if (deliver_hold) begin
      ifid_instr_o = buf_q;
      ifid_pc_o    = req_pc_q;
    end
  end

  // Sequencer state, request PC, discard flag and stall buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
      buf_q     <= '0;
      req_pc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH;
        S_FETCH: begin
          if (redirect) begin
            state_q <= S_FETCH;
          end else if (halt_i) begin
            state_q <= S_HALTED;
          end else if (pc_enable_o) begin
            req_pc_q <= pc_i;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_valid_i) begin
            discard_q <= 1'b0;
            if (!redirect && !discard_q && stall_i) begin
              buf_q   <= imem_rdata_i;
              state_q <= S_HOLD;
            end else begin
              state_q <= S_FETCH;
            end
          end else if (redirect) begin
            // Response still in flight; remember to drop it.
            discard_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            buf_q   <= '0;
            state_q <= S_FETCH;
          end else if (!stall_i) begin
            state_q <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (trap_i || resume_i) state_q <= S_FETCH;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with a delivery scoreboard.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i;
  logic        pc_load_o;
  logic [31:0] pc_load_val_o;
  logic        pc_enable_o;
  logic        stall_i, trap_i, br_redirect_i, jmp_redirect_i, halt_i, resume_i;
  logic [31:0] br_target_i, jmp_target_i;
  logic        imem_req_o, imem_ready_i, imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o, ifid_pc_o;
  logic        flush_ifid_o, flush_idex_o, halted_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pc_r;
  logic [102:0] all_out;

  assign pc_i = pc_r;
  assign all_out = {pc_load_o, pc_load_val_o, pc_enable_o, imem_req_o, ifid_valid_o,
                    ifid_instr_o, ifid_pc_o, flush_ifid_o, flush_idex_o, halted_o};

  pc_sequencer #(.PC_WIDTH(32), .TRAP_VEC(32'h40), .INSTR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pc_i(pc_i),
    .pc_load_o(pc_load_o), .pc_load_val_o(pc_load_val_o), .pc_enable_o(pc_enable_o),
    .stall_i(stall_i), .trap_i(trap_i), .br_redirect_i(br_redirect_i),
    .br_target_i(br_target_i), .jmp_redirect_i(jmp_redirect_i), .jmp_target_i(jmp_target_i),
    .halt_i(halt_i), .resume_i(resume_i),
    .imem_req_o(imem_req_o), .imem_ready_i(imem_ready_i),
    .imem_valid_i(imem_valid_i), .imem_rdata_i(imem_rdata_i),
    .ifid_valid_o(ifid_valid_o), .ifid_instr_o(ifid_instr_o), .ifid_pc_o(ifid_pc_o),
    .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  // Program counter model driven by the sequencer's strobes.
  always @(posedge clk) begin
    if (reset)            pc_r <= '0;
    else if (pc_load_o)   pc_r <= pc_load_val_o;
    else if (pc_enable_o) pc_r <= pc_r + 32'd1;
  end

  // Scoreboard: every IF/ID delivery must match the oldest expected entry.
  always @(negedge clk) begin
    n_checks++;
    if (pc_load_o === 1'b1 && pc_enable_o === 1'b1) begin
      n_fail++;
      $display("FAIL load_enable_exclusive: both strobes high at %0t", $time);
    end
    if (ifid_valid_o === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_delivery: got pc=%h instr=%h, expected none", ifid_pc_o, ifid_instr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({ifid_pc_o, ifid_instr_o} !== e) begin
          n_fail++;
          $display("FAIL delivery: got pc=%h instr=%h, expected pc=%h instr=%h",
                   ifid_pc_o, ifid_instr_o, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch from a FETCH window; ends in the next FETCH window.
  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    n_checks++;
    if ({imem_req_o, pc_enable_o, pc_i, ifid_valid_o} !== {1'b1, 1'b1, addr, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_req: got req=%b en=%b pc=%h vld=%b, expected 1 1 %h 0",
               imem_req_o, pc_enable_o, pc_i, ifid_valid_o, addr);
    end
    tick();
    imem_valid_i = 1'b1;
    imem_rdata_i = data;
    exp_q.push_back({addr, data});
    @(negedge clk);
    n_checks++;
    if (ifid_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_resp: got ifid_valid=%b, expected 1 (pc %h)", ifid_valid_o, addr);
    end
    tick();
    imem_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ready_i = 1'b1;
    trap_i = 1'b1; br_redirect_i = 1'b1; jmp_redirect_i = 1'b1; halt_i = 1'b0; resume_i = 1'b1;
    br_target_i = 32'h80; jmp_target_i = 32'h90; stall_i = 1'b0;
    imem_valid_i = 1'b1; imem_rdata_i = 32'hFFFF;
    repeat (3) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (all_out !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %h, expected all zero", all_out);
      end
    end
    tick();
    trap_i = 1'b0; br_redirect_i = 1'b0; jmp_redirect_i = 1'b0; resume_i = 1'b0;
    imem_valid_i = 1'b0; imem_rdata_i = '0;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_cycle_req: got %b, expected 0", imem_req_o);
    end
    tick();
  endtask

  task automatic test_sequential();
    fetch_one(32'd0, 32'h13);
    fetch_one(32'd1, 32'h101);
    fetch_one(32'd2, 32'h102);
  endtask

  task automatic test_branch();
    @(negedge clk);
    n_checks++;
    if ({imem_req_o, pc_i} !== {1'b1, 32'd3}) begin
      n_fail++;
      $display("FAIL branch_setup: got req=%b pc=%h, expected 1 3", imem_req_o, pc_i);
    end
    tick();
    br_redirect_i = 1'b1; br_target_i = 32'h80;
    @(negedge clk);
    n_checks++;
    if ({pc_load_o, pc_load_val_o, flush_ifid_o, flush_idex_o, pc_enable_o, ifid_valid_o}
        !== {1'b1, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL branch_wait: got ld=%b val=%h fi=%b fe=%b en=%b v=%b, expected 1 80 1 1 0 0",
               pc_load_o, pc_load_val_o, flush_ifid_o, flush_idex_o, pc_enable_o, ifid_valid_o);
    end
    tick();
    br_redirect_i = 1'b0;
    imem_valid_i = 1'b1; imem_rdata_i = 32'hDEAD;
    @(negedge clk);
    n_checks++;
    if (ifid_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_discard: got ifid_valid=%b, expected 0", ifid_valid_o);
    end
    tick();
    imem_valid_i = 1'b0;
    fetch_one(32'h80, 32'h1111);
  endtask

  task automatic test_redirects();
    trap_i = 1'b1; br_redirect_i = 1'b1; jmp_redirect_i = 1'b1;
    br_target_i = 32'h80; jmp_target_i = 32'h90;
    @(negedge clk);
    n_checks++;
    if ({pc_load_o, pc_load_val_o, pc_enable_o, imem_req_o, flush_ifid_o, flush_idex_o}
        !== {1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL trap_priority: got ld=%b val=%h en=%b req=%b fi=%b fe=%b, expected 1 40 0 0 1 1",
               pc_load_o, pc_load_val_o, pc_enable_o, imem_req_o, flush_ifid_o, flush_idex_o);
    end
    tick();
    trap_i = 1'b0; br_redirect_i = 1'b0; jmp_redirect_i = 1'b0;
    fetch_one(32'h40, 32'h2222);
    jmp_redirect_i = 1'b1; jmp_target_i = 32'h90;
    @(negedge clk);
    n_checks++;
    if ({pc_load_o, pc_load_val_o, pc_enable_o, imem_req_o, flush_ifid_o, flush_idex_o}
        !== {1'b1, 32'h90, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_fetch: got ld=%b val=%h en=%b req=%b fi=%b fe=%b, expected 1 90 0 0 1 0",
               pc_load_o, pc_load_val_o, pc_enable_o, imem_req_o, flush_ifid_o, flush_idex_o);
    end
    tick();
    jmp_redirect_i = 1'b0;
    @(negedge clk);
    tick();
    jmp_redirect_i = 1'b1; jmp_target_i = 32'hA0;
    imem_valid_i = 1'b1; imem_rdata_i = 32'h3333;
    @(negedge clk);
    n_checks++;
    if ({pc_load_o, pc_load_val_o, ifid_valid_o} !== {1'b1, 32'hA0, 1'b0}) begin
      n_fail++;
      $display("FAIL jump_with_valid: got ld=%b val=%h v=%b, expected 1 a0 0",
               pc_load_o, pc_load_val_o, ifid_valid_o);
    end
    tick();
    jmp_redirect_i = 1'b0; imem_valid_i = 1'b0;
    fetch_one(32'hA0, 32'h4444);
  endtask

  task automatic test_stall_hold();
    stall_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({imem_req_o, pc_enable_o, pc_i} !== {1'b0, 1'b0, 32'hA1}) begin
        n_fail++;
        $display("FAIL stall_fetch: got req=%b en=%b pc=%h, expected 0 0 a1", imem_req_o, pc_enable_o, pc_i);
      end
      tick();
    end
    stall_i = 1'b0;
    @(negedge clk);
    tick();
    stall_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'hABCD;
    exp_q.push_back({32'hA1, 32'hABCD});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ifid_valid_o, imem_req_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_stalled: got v=%b req=%b, expected 0 0", ifid_valid_o, imem_req_o);
      end
      tick();
      imem_valid_i = 1'b0;
    end
    stall_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ifid_valid_o, ifid_instr_o, ifid_pc_o} !== {1'b1, 32'hABCD, 32'hA1}) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b instr=%h pc=%h, expected 1 abcd a1",
               ifid_valid_o, ifid_instr_o, ifid_pc_o);
    end
    tick();
    fetch_one(32'hA2, 32'h5555);
    @(negedge clk);
    tick();
    stall_i = 1'b1; imem_valid_i = 1'b1; imem_rdata_i = 32'h6666;
    @(negedge clk);
    tick();
    imem_valid_i = 1'b0; trap_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({pc_load_o, pc_load_val_o, flush_idex_o, ifid_valid_o} !== {1'b1, 32'h40, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_trap: got ld=%b val=%h fe=%b v=%b, expected 1 40 1 0",
               pc_load_o, pc_load_val_o, flush_idex_o, ifid_valid_o);
    end
    tick();
    trap_i = 1'b0; stall_i = 1'b0;
    fetch_one(32'h40, 32'h7777);
  endtask

  task automatic test_halt();
    halt_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({imem_req_o, pc_enable_o, halted_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL halt_entry: got req=%b en=%b h=%b, expected 0 0 0", imem_req_o, pc_enable_o, halted_o);
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      jmp_redirect_i = (i == 5); jmp_target_i = 32'h200;
      @(negedge clk);
      n_checks++;
      if ({halted_o, imem_req_o, pc_load_o, flush_ifid_o} !== 4'b1000) begin
        n_fail++;
        $display("FAIL halted_idle: got h=%b req=%b ld=%b fi=%b, expected 1 0 0 0",
                 halted_o, imem_req_o, pc_load_o, flush_ifid_o);
      end
      tick();
    end
    jmp_redirect_i = 1'b0; halt_i = 1'b0; resume_i = 1'b1;
    @(negedge clk);
    tick();
    resume_i = 1'b0;
    fetch_one(32'h41, 32'h8888);
    halt_i = 1'b1;
    @(negedge clk);
    tick();
    halt_i = 1'b0; trap_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({halted_o, pc_load_o, pc_load_val_o} !== {1'b1, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL halt_trap: got h=%b ld=%b val=%h, expected 1 1 40", halted_o, pc_load_o, pc_load_val_o);
    end
    tick();
    trap_i = 1'b0;
    fetch_one(32'h40, 32'h9999);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got %h, expected all zero", all_out);
    end
    tick();
    reset = 1'b0; imem_valid_i = 1'b1; imem_rdata_i = 32'h55;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL late_response_idle: got %h, expected all zero", all_out);
    end
    tick();
    imem_valid_i = 1'b0;
    fetch_one(32'd0, 32'hAAAA);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_redirects();
    test_stall_hold();
    test_halt();
    test_reset_midflight();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
